leds_on: RTL and testbench

LEDS_ON -- requirements
Module: leds_on

---
 rtl/leds_pkg.sv | 9 +
 rtl/leds_pwm.sv | 26 ++
 rtl/leds_on.sv | 75 +++++++
 tb/tb_leds_on.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared constants for the LED driver slice: port width and parameter defaults.
package leds_pkg;

    localparam int              LED_W                = 8;
    localparam logic [LED_W-1:0] DEF_ON_PATTERN      = 8'hFF;
    localparam int              DEF_PWM_BITS         = 4;
    localparam int              DEF_RAMP_STEP_CYCLES = 0;

endpackage

// File: rtl/leds_pwm.sv
// Free-running PWM counter with a registered "counter below duty" compare.
module leds_pwm
    import leds_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PWM_BITS:0] duty,
    output logic              pwm_on
);

    logic [PWM_BITS-1:0] cnt;

    // duty is one bit wider than cnt, so duty == 2^PWM_BITS is always above cnt (100 %).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            pwm_on <= 1'b0;
        end else begin
            cnt    <= cnt + 1'b1;
            pwm_on <= ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/leds_on.sv
// LED enable with optional soft-start ramp: owns the step timer, the duty register
// and the ON_PATTERN gating; the PWM counter/compare lives in leds_pwm.
module leds_on
    import leds_pkg::*;
#(
    parameter logic [LED_W-1:0] ON_PATTERN       = DEF_ON_PATTERN,
    parameter int               PWM_BITS         = DEF_PWM_BITS,
    parameter int               RAMP_STEP_CYCLES = DEF_RAMP_STEP_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    output logic [LED_W-1:0] LPORT,
    output logic             READY
);

    localparam int TW   = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam int LAST = (RAMP_STEP_CYCLES > 0) ? RAMP_STEP_CYCLES - 1 : 0;
    localparam logic [TW-1:0]     T_LAST = TW'(LAST);
    localparam logic [PWM_BITS:0] FULL   = {1'b1, {PWM_BITS{1'b0}}};

    logic [PWM_BITS:0] duty;
    logic [PWM_BITS:0] duty_nxt;
    logic [PWM_BITS:0] duty_gated;
    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_nxt;
    logic              pwm_on;

    always_comb begin
        duty_nxt = duty;
        tmr_nxt  = tmr;
        if (!EN) begin
            duty_nxt = '0;
            tmr_nxt  = '0;
        end else if (RAMP_STEP_CYCLES == 0) begin
            duty_nxt = FULL;
        end else if (tmr == T_LAST) begin
            tmr_nxt = '0;
            if (duty != FULL) begin
                duty_nxt = duty + 1'b1;
            end
        end else begin
            tmr_nxt = tmr + 1'b1;
        end
    end

    // READY is a level, not a handshake: registered, high while the next duty is
    // full scale and EN is high (duty_nxt is already forced to 0 when EN is low).
    always_ff @(posedge clk) begin
        if (rst) begin
            duty  <= '0;
            tmr   <= '0;
            READY <= 1'b0;
        end else begin
            duty  <= duty_nxt;
            tmr   <= tmr_nxt;
            READY <= (duty_nxt == FULL);
        end
    end

    // Zero duty into the compare while EN is low so the LEDs blank on the very next clock.
    assign duty_gated = EN ? duty : '0;

    leds_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (duty_gated),
        .pwm_on (pwm_on)
    );

    assign LPORT = ON_PATTERN & {LED_W{pwm_on}};

endmodule

// File: tb/tb_leds_on.sv
// Randomized/directed bench for leds_on: three parameterizations share rst/EN and
// are compared every cycle against a behavioural model through an expected queue.
module tb_leds_on;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] lport_a, lport_b, lport_c;
    logic       ready_a, ready_b, ready_c;

    int n_vec  = 0;
    int n_miss = 0;

    logic [26:0] exp_q[$];

    // Model state and parameters per instance: a = defaults, b = 8'hA5, c = ramp 2.
    logic [7:0] m_pat [3] = '{8'hFF, 8'hA5, 8'hFF};
    int         m_bits[3] = '{4, 4, 4};
    int         m_n   [3] = '{0, 0, 2};
    int         m_d   [3];
    int         m_t   [3];
    int         m_p   [3];

    leds_on dut_a (
        .clk (clk), .rst (rst), .EN (en), .LPORT (lport_a), .READY (ready_a)
    );

    leds_on #(.ON_PATTERN (8'hA5), .RAMP_STEP_CYCLES (0)) dut_b (
        .clk (clk), .rst (rst), .EN (en), .LPORT (lport_b), .READY (ready_b)
    );

    leds_on #(.PWM_BITS (4), .RAMP_STEP_CYCLES (2)) dut_c (
        .clk (clk), .rst (rst), .EN (en), .LPORT (lport_c), .READY (ready_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs each instance shows after the coming clock edge, from the rules:
    // lit = EN and P < D; D cleared by !EN, jumps to full or steps every N clocks.
    task automatic model_step(input logic r, input logic e, output logic [26:0] exp);
        exp = '0;
        for (int k = 0; k < 3; k++) begin
            int         full;
            logic [7:0] lp;
            logic       rd;
            full = 1 << m_bits[k];
            if (r) begin
                lp = 8'h00; rd = 1'b0;
                m_d[k] = 0; m_t[k] = 0; m_p[k] = 0;
            end else begin
                lp = (e && (m_p[k] < m_d[k])) ? m_pat[k] : 8'h00;
                if (!e) begin
                    m_d[k] = 0; m_t[k] = 0;
                end else if (m_n[k] == 0) begin
                    m_d[k] = full;
                end else if (m_t[k] == m_n[k] - 1) begin
                    m_t[k] = 0;
                    if (m_d[k] < full) m_d[k] = m_d[k] + 1;
                end else begin
                    m_t[k] = m_t[k] + 1;
                end
                rd = e && (m_d[k] == full);
                m_p[k] = (m_p[k] + 1) % full;
            end
            exp[9*(2-k) +: 9] = {rd, lp};
        end
    endtask

    // driver: inputs change just after the falling edge, expectation queued for the next rise
    task automatic cycle(input logic r, input logic e);
        logic [26:0] exp;
        @(negedge clk);
        #1;
        rst = r;
        en  = e;
        model_step(r, e, exp);
        exp_q.push_back(exp);
    endtask

    // Runs EN high and reports how many clocks after the start each READY first rose.
    task automatic run_on(input int cycles, output int first_a, output int first_c);
        first_a = -1;
        first_c = -1;
        for (int i = 1; i <= cycles; i++) begin
            cycle(1'b0, 1'b1);
            if (first_a < 0 && ready_a) first_a = i - 1;
            if (first_c < 0 && ready_c) first_c = i - 1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [26:0] e;
            e = exp_q.pop_front();
            chk("dut_a", {23'd0, ready_a, lport_a}, {23'd0, e[26:18]});
            chk("dut_b", {23'd0, ready_b, lport_b}, {23'd0, e[17:9]});
            chk("dut_c", {23'd0, ready_c, lport_c}, {23'd0, e[8:0]});
        end
    end

    initial begin
        int fa, fc, guard;
        rst = 1'b1;
        en  = 1'b1;

        // reset two clocks, then steady on / ramp to full
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        run_on(40, fa, fc);
        chk("ready_a_rise", fa, 1);
        chk("ready_c_rise", fc, 32);

        // EN low for three clocks, then the ramp restarts from zero
        repeat (3) cycle(1'b0, 1'b0);
        run_on(40, fa, fc);
        chk("ready_c_rise_after_en", fc, 32);

        // EN falls exactly on a duty-step clock mid-ramp
        cycle(1'b0, 1'b0);
        guard = 0;
        while (!(m_t[2] == m_n[2] - 1 && m_d[2] > 0 && m_d[2] < 16) && guard < 100) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        chk("step_clock_reached", int'(guard < 100), 1);
        cycle(1'b0, 1'b0);
        run_on(40, fa, fc);
        chk("ready_c_rise_after_step_clear", fc, 32);

        // reset pulse at D = 7 mid-ramp
        cycle(1'b0, 1'b0);
        guard = 0;
        while (m_d[2] != 7 && guard < 100) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        chk("duty7_reached", int'(guard < 100), 1);
        cycle(1'b1, 1'b1);
        run_on(40, fa, fc);
        chk("ready_a_rise_after_rst", fa, 1);
        chk("ready_c_rise_after_rst", fc, 32);

        // random EN with occasional reset
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0));
        end

        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
